io_port_arbiter: RTL and testbench



---
 rtl/io_port_arbiter.sv | 116 +++++++++++
 tb/tb_io_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/io_port_arbiter.sv
// Merges per-core outbound port messages onto one io-filter port set with per-port round-robin,
// and broadcasts the filter's inbound port messages back to every core.
module io_port_arbiter #(
    parameter int unsigned NUM_CORES  = 2,
    parameter int unsigned IO_PINS    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    localparam int unsigned PORTS     = IO_PINS + 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_CORES*PORTS-1:0]            core_active_out,
    input  logic [NUM_CORES*PORTS*DATA_WIDTH-1:0] core_data_out,
    output logic [NUM_CORES*PORTS-1:0]            core_busy,
    output logic [NUM_CORES*PORTS-1:0]            core_active_in,
    output logic [NUM_CORES*PORTS*DATA_WIDTH-1:0] core_data_in,
    output logic [PORTS-1:0]                      port_active_out,
    output logic [PORTS*DATA_WIDTH-1:0]           port_data_out,
    input  logic [PORTS-1:0]                      port_active_in,
    input  logic [PORTS*DATA_WIDTH-1:0]           port_data_in
);
    localparam int unsigned RrW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int NC = int'(NUM_CORES);
    localparam int NP = int'(PORTS);
    localparam int DW = int'(DATA_WIDTH);
    localparam int OutOnly = int'(IO_PINS);
    localparam int InOnly = int'(IO_PINS) + 1;

    logic [NUM_CORES*PORTS-1:0]            valid_q, valid_d;
    logic [NUM_CORES*PORTS*DATA_WIDTH-1:0] data_q, data_d;
    logic [PORTS-1:0][RrW-1:0]             rr_q, rr_d;
    logic [PORTS-1:0]                      port_active_q, port_active_d;
    logic [PORTS*DATA_WIDTH-1:0]           port_data_q, port_data_d;
    logic [NUM_CORES*PORTS-1:0]            core_active_in_q, core_active_in_d;
    logic [NUM_CORES*PORTS*DATA_WIDTH-1:0] core_data_in_q, core_data_in_d;

    always_comb begin
        logic found;
        int   idx;
        int   slot;
        found            = 1'b0;
        idx              = 0;
        slot             = 0;
        valid_d          = valid_q;
        data_d           = data_q;
        rr_d             = rr_q;
        port_active_d    = '0;
        port_data_d      = port_data_q;
        core_active_in_d = '0;
        core_data_in_d   = core_data_in_q;

        // Round-robin search per port, starting at rr_q[p] and wrapping.
        for (int p = 0; p < NP; p++) begin
            found = 1'b0;
            for (int k = 0; k < NC; k++) begin
                idx = int'(rr_q[p]) + k;
                if (idx >= NC) idx = idx - NC;
                slot = idx * NP + p;
                if (!found && valid_q[slot]) begin
                    found                   = 1'b1;
                    port_active_d[p]        = 1'b1;
                    port_data_d[p*DW +: DW] = data_q[slot*DW +: DW];
                    valid_d[slot]           = 1'b0;
                    rr_d[p]                 = (idx == NC - 1) ? '0 : RrW'(idx + 1);
                end
            end
        end

        // Capture looks only at valid_q, so a request into a slot granted this edge is dropped.
        for (int c = 0; c < NC; c++) begin
            for (int p = 0; p < NP; p++) begin
                slot = c * NP + p;
                if (p != InOnly && core_active_out[slot] && !valid_q[slot]) begin
                    valid_d[slot]            = 1'b1;
                    data_d[slot*DW +: DW]    = core_data_out[slot*DW +: DW];
                end
                if (p != OutOnly) begin
                    core_active_in_d[slot] = port_active_in[p];
                    if (port_active_in[p]) begin
                        core_data_in_d[slot*DW +: DW] = port_data_in[p*DW +: DW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q          <= '0;
            data_q           <= '0;
            rr_q             <= '0;
            port_active_q    <= '0;
            port_data_q      <= '0;
            core_active_in_q <= '0;
            core_data_in_q   <= '0;
        end else begin
            valid_q          <= valid_d;
            data_q           <= data_d;
            rr_q             <= rr_d;
            port_active_q    <= port_active_d;
            port_data_q      <= port_data_d;
            core_active_in_q <= core_active_in_d;
            core_data_in_q   <= core_data_in_d;
        end
    end

    assign core_busy       = valid_q;
    assign core_active_in  = core_active_in_q;
    assign core_data_in    = core_data_in_q;
    assign port_active_out = port_active_q;
    assign port_data_out   = port_data_q;

    // Requests/data for direction-restricted ports are intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{core_active_out, core_data_out, port_active_in, port_data_in};

endmodule

// File: tb/tb_io_port_arbiter.sv
// Scoreboard bench for io_port_arbiter: expected outbound messages are queued per port
// at request time and popped by a monitor when the DUT emits them.
module tb_io_port_arbiter;
    localparam int NC = 2;
    localparam int IP = 4;
    localparam int DW = 8;
    localparam int P  = IP + 2;

    logic                 clk;
    logic                 rst_n;
    logic [NC*P-1:0]      core_active_out;
    logic [NC*P*DW-1:0]   core_data_out;
    logic [NC*P-1:0]      core_busy;
    logic [NC*P-1:0]      core_active_in;
    logic [NC*P*DW-1:0]   core_data_in;
    logic [P-1:0]         port_active_out;
    logic [P*DW-1:0]      port_data_out;
    logic [P-1:0]         port_active_in;
    logic [P*DW-1:0]      port_data_in;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q [P][$];

    io_port_arbiter #(
        .NUM_CORES  (NC),
        .IO_PINS    (IP),
        .DATA_WIDTH (DW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_active_out (core_active_out),
        .core_data_out   (core_data_out),
        .core_busy       (core_busy),
        .core_active_in  (core_active_in),
        .core_data_in    (core_data_in),
        .port_active_out (port_active_out),
        .port_data_out   (port_data_out),
        .port_active_in  (port_active_in),
        .port_data_in    (port_data_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pdo(input int p);
        return port_data_out[p*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] cdi(input int c, input int p);
        return core_data_in[(c*P+p)*DW +: DW];
    endfunction

    task automatic req(input int c, input int p, input logic [DW-1:0] d);
        core_active_out[c*P+p]          = 1'b1;
        core_data_out[(c*P+p)*DW +: DW] = d;
    endtask

    // Advance one cycle; strobes are single-cycle.
    task automatic step();
        @(posedge clk);
        #1;
        core_active_out = '0;
        port_active_in  = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < P; p++) begin
                if (port_active_out[p]) begin
                    if (exp_q[p].size() == 0) check("sb_unexpected_out", 128'(port_active_out[p]), 0);
                    else check("sb_out_data", 128'(pdo(p)), 128'(exp_q[p].pop_front()));
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b1;
        core_active_out = '0;
        core_data_out   = '0;
        port_active_in  = '0;
        port_data_in    = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 128'(core_busy), 0);
        check("rst_pao", 128'(port_active_out), 0);
        check("rst_pdo", 128'(port_data_out), 0);
        check("rst_cai", 128'(core_active_in), 0);
        check("rst_cdi", 128'(core_data_in), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Uncontested
        req(0, 2, 8'hFF); exp_q[2].push_back(8'hFF);
        step();
        check("t1_busy_c1", 128'(core_busy), 12'h004);
        check("t1_pao_c1", 128'(port_active_out), 0);
        step();
        check("t1_pao_c2", 128'(port_active_out), 6'b000100);
        check("t1_data_c2", 128'(pdo(2)), 8'hFF);
        check("t1_busy_c2", 128'(core_busy), 0);
        step();
        check("t1_pao_c3", 128'(port_active_out), 0);
        check("t1_hold_c3", 128'(pdo(2)), 8'hFF);

        // Contention and fairness on port 0
        req(0, 0, 8'h11); req(1, 0, 8'h22);
        exp_q[0].push_back(8'h11); exp_q[0].push_back(8'h22);
        step();
        check("t2_busy_c1", 128'(core_busy), 12'h041);
        step();
        check("t2_pao_c2", 128'(port_active_out), 6'b000001);
        check("t2_data_c2", 128'(pdo(0)), 8'h11);
        check("t2_busy_c2", 128'(core_busy), 12'h040);
        step();
        check("t2_pao_c3", 128'(port_active_out), 6'b000001);
        check("t2_data_c3", 128'(pdo(0)), 8'h22);
        check("t2_busy_c3", 128'(core_busy), 0);
        step();
        req(0, 0, 8'h33); exp_q[0].push_back(8'h33);
        step();
        step();
        check("t2_solo_data", 128'(pdo(0)), 8'h33);
        req(0, 0, 8'h44); req(1, 0, 8'h55);
        exp_q[0].push_back(8'h55); exp_q[0].push_back(8'h44);
        step();
        step();
        check("t2_rr_first", 128'(pdo(0)), 8'h55);
        step();
        check("t2_rr_second", 128'(pdo(0)), 8'h44);
        step();

        // Request while busy is dropped
        req(0, 1, 8'hAA); exp_q[1].push_back(8'hAA);
        step();
        req(0, 1, 8'hBB);
        step();
        check("t3_pao_c2", 128'(port_active_out), 6'b000010);
        check("t3_data_c2", 128'(pdo(1)), 8'hAA);
        check("t3_busy_c2", 128'(core_busy), 0);
        step();
        check("t3_pao_c3", 128'(port_active_out), 0);
        repeat (3) step();

        // Direction restrictions
        req(1, 5, 8'h77); req(1, 4, 8'h03); exp_q[4].push_back(8'h03);
        step();
        check("t4_busy_c1", 128'(core_busy), 12'h400);
        step();
        check("t4_pao_c2", 128'(port_active_out), 6'b010000);
        check("t4_data_c2", 128'(pdo(4)), 8'h03);
        check("t4_p5_data", 128'(pdo(5)), 0);
        step();

        // Inbound broadcast
        port_active_in = 6'b100000; port_data_in[5*DW +: DW] = 8'h5A;
        step();
        check("t5_cai_c1", 128'(core_active_in), 12'h820);
        check("t5_cdi0", 128'(cdi(0, 5)), 8'h5A);
        check("t5_cdi1", 128'(cdi(1, 5)), 8'h5A);
        port_data_in[5*DW +: DW] = 8'h11;
        step();
        check("t5_cai_c2", 128'(core_active_in), 0);
        check("t5_hold", 128'(cdi(1, 5)), 8'h5A);
        port_active_in = 6'b010000; port_data_in[4*DW +: DW] = 8'h99;
        step();
        check("t5_p4_cai", 128'(core_active_in), 0);
        check("t5_p4_cdi", 128'(cdi(0, 4)), 0);
        port_active_in = 6'b000001; port_data_in[0 +: DW] = 8'hC3;
        step();
        check("t5_p0_cai", 128'(core_active_in), 12'h041);
        check("t5_p0_cdi", 128'(cdi(1, 0)), 8'hC3);
        step();

        // Reset mid-operation discards the pending slot and rewinds rr
        req(0, 3, 8'hEE);
        step();
        check("t6_busy_c1", 128'(core_busy), 12'h008);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 128'(core_busy), 0);
        check("t6_rst_pao", 128'(port_active_out), 0);
        check("t6_rst_pdo", 128'(port_data_out), 0);
        check("t6_rst_cai", 128'(core_active_in), 0);
        check("t6_rst_cdi", 128'(core_data_in), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) step();
        req(0, 0, 8'h60); req(1, 0, 8'h61); req(1, 2, 8'h62);
        exp_q[0].push_back(8'h60); exp_q[0].push_back(8'h61); exp_q[2].push_back(8'h62);
        step();
        step();
        check("t6_pao_multi", 128'(port_active_out), 6'b000101);
        check("t6_rr_reset", 128'(pdo(0)), 8'h60);
        check("t6_p2_data", 128'(pdo(2)), 8'h62);
        step();
        check("t6_second", 128'(pdo(0)), 8'h61);
        repeat (3) step();

        for (int p = 0; p < P; p++) check("sb_drain", 128'(exp_q[p].size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
